// File: rtl/jk_mod_counter_pkg.sv
// Shared JK excitation codes and helpers for the mod-N counter slice.
// Codes are packed as {J, K}.
package jk_mod_counter_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TOG  = 2'b11;

   // Plain counting step: toggle when the bit changes, otherwise hold.
   function automatic logic [1:0] jkStep(input logic cur, input logic nxt);
      return (cur == nxt) ? JK_HOLD : JK_TOG;
   endfunction

   // Forced value (wrap or load): J = target, K = ~target.
   function automatic logic [1:0] jkForce(input logic target);
      return target ? JK_SET : JK_RST;
   endfunction

endpackage

// File: rtl/jk_mod_counter_jk_cell.sv
// Single JK flip-flop with a synchronous active-low reset.
module jk_cell
   import jk_mod_counter_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   logic stateQ;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stateQ <= 1'b0;
      end else begin
         case ({j, k})
            JK_HOLD: stateQ <= stateQ;
            JK_RST:  stateQ <= 1'b0;
            JK_SET:  stateQ <= 1'b1;
            default: stateQ <= ~stateQ;
         endcase
      end
   end

   assign q = stateQ;

endmodule

// File: rtl/jk_mod_counter.sv
// Mod-N up/down counter whose bits are JK cells; next-state and J/K excitation live here.
// tc pulses for one cycle after a wrap; err latches an out-of-range load until reset.
module jk_mod_counter
   import jk_mod_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             err
);

   // One extra bit so MODULUS == 2**WIDTH still compares correctly.
   localparam int              EXT_W     = WIDTH + 1;
   localparam logic [WIDTH:0]   MOD_EXT   = EXT_W'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] countQ;
   logic [WIDTH-1:0] countD;
   logic             forceD;
   logic             tcQ;
   logic             tcD;
   logic             errQ;
   logic             errD;
   logic             dinLegal;
   logic [WIDTH-1:0] jVec;
   logic [WIDTH-1:0] kVec;

   assign dinLegal = ({1'b0, din} < MOD_EXT);

   always_comb begin
      countD = countQ;
      forceD = 1'b0;
      tcD    = 1'b0;
      errD   = errQ;
      if (load) begin
         forceD = 1'b1;
         countD = dinLegal ? din : '0;
         errD   = errQ | ~dinLegal;
      end else if (en && up) begin
         if (countQ == MAX_COUNT) begin
            countD = '0;
            forceD = 1'b1;
            tcD    = 1'b1;
         end else begin
            countD = countQ + WIDTH'(1);
         end
      end else if (en) begin
         if (countQ == '0) begin
            countD = MAX_COUNT;
            forceD = 1'b1;
            tcD    = 1'b1;
         end else begin
            countD = countQ - WIDTH'(1);
         end
      end
   end

   always_comb begin
      jVec = '0;
      kVec = '0;
      for (int i = 0; i < WIDTH; i++) begin
         {jVec[i], kVec[i]} = forceD ? jkForce(countD[i]) : jkStep(countQ[i], countD[i]);
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : gCell
      jk_cell uCell (
         .clk   (clk),
         .reset (reset),
         .j     (jVec[g]),
         .k     (kVec[g]),
         .q     (countQ[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tcQ  <= 1'b0;
         errQ <= 1'b0;
      end else begin
         tcQ  <= tcD;
         errQ <= errD;
      end
   end

   assign q   = countQ;
   assign tc  = tcQ;
   assign err = errQ;

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous mod-N up/down counter built from per-bit JK flip-flop cells.
- Consumes the team's JK flip-flop stage: each bit's J/K excitation is generated here and fed to a JK cell.
- Used as the next integration step above the single JK flip-flop, and as a clock-divider/sequencer for downstream labs.
- Provides load, enable, direction, terminal-count pulse and wrap-around.

Parameters:
- WIDTH, 4, counter width in bits (2..16).
- MODULUS, 10, count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (reset=0 at a rising clk edge clears the block).
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- din  input  WIDTH  load value.
- q  output  WIDTH  current count.
- tc  output  1  terminal count, registered, one cycle wide.
- err  output  1  sticky flag: an illegal load value was presented.

Behaviour:
- Clock and reset:
  - Single clock domain; all state changes only on the rising edge of clk.
  - reset=0 at an edge forces q=0, tc=0 and err=0, regardless of en, load or up.
- Priority per edge: reset > load > en > hold.
- Load:
  - If din < MODULUS, then q <= din and tc <= 0.
  - If din >= MODULUS, then q <= 0 and err <= 1. err stays 1 until reset.
- Count up (en=1, up=1): q <= q+1, except when q == MODULUS-1, then q <= 0.
- Count down (en=1, up=0): q <= q-1, except when q == 0, then q <= MODULUS-1.
- Hold: en=0 and load=0 leaves q unchanged and drives tc <= 0.
- tc:
  - tc <= 1 on exactly the edge where a wrap occurs: up-wrap MODULUS-1 -> 0, or down-wrap 0 -> MODULUS-1.
  - tc is high for the following cycle only.
  - Load never asserts tc.
- Latency: q and tc reflect the inputs sampled at edge n immediately after edge n. No combinational path from inputs to outputs.
- Implementation rule (fixed):
  - Each bit is a JK cell. The combinational excitation logic computes J[i]/K[i] per bit.
  - Plain count: J=K=1 to toggle, J=K=0 to hold.
  - Wrap and load: J=target, K=~target.
  - Reset is applied inside the cells.
- Direction change mid-count takes effect on the next enabled edge. There is no extra state.
- Reset deasserted mid-sequence: counting resumes from 0 on the first edge with reset=1 and en=1.
- MODULUS == 2^WIDTH: wrap is natural binary overflow; tc still pulses on wrap.
- q never leaves the range 0..MODULUS-1 after reset.

Decomposition:
- Shared package holds:
  - JK code constants (HOLD=2'b00, RST=2'b01, SET=2'b10, TOG=2'b11).
  - A function mapping (current bit, next bit) to a JK pair.
- One sub-module, jk_cell: a single JK flip-flop with clk, active-low synchronous reset, J, K and Q. It is instantiated WIDTH times via generate.
- Next-state and excitation logic live in jk_mod_counter itself.

Test Plan:
- Reset then count up: reset=0 for 2 cycles, then en=1, up=1 for 12 cycles (WIDTH=4, MODULUS=10).
  - Expect q = 0,1,...,9,0,1.
  - Expect tc=1 only in the cycle after 9->0.
- Count down wrap: load din=1, then en=1, up=0 for 3 cycles.
  - Expect q = 1,0,9,8.
  - Expect tc=1 in the cycle after 0->9.
- Load priority: q=5, then load=1, din=7 together with en=1, up=1.
  - Expect q=7 and tc=0.
  - Next edge, en=1: expect q=8.
- Illegal load: din=12 with load=1.
  - Expect q=0 and err=1.
  - err stays 1 through 20 counting cycles and clears only after reset=0.
- Hold and direction flip: q=3, en=0 for 4 cycles, then up toggles every cycle with en=1.
  - Expect q = 3,3,3,3 during the hold, then 4,3,4,3.
  - Expect tc=0 throughout.
- Reset mid-operation: at q=6 with en=1, assert reset=0 for one edge.
  - Expect q=0 and tc=0 on that edge.
  - Expect q=1 on the next enabled edge.
  - Repeat the whole suite with WIDTH=3, MODULUS=8 to check natural overflow.
